alu_seq: RTL

//  Parametrised, registered successor to the i281 combinational ALU. It keeps op encodings 0-3 ({c13,c12}) and the 4-bit flag output.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  alu_pkg : op encodings, flag bit positions and MUL FSM states for alu_seq
//  Revision: 1.0
// ============================================================================
package alu_pkg;

   localparam logic [2:0] OP_SHL = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_SHR = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam int FLG_C = 3;
   localparam int FLG_N = 2;
   localparam int FLG_V = 1;
   localparam int FLG_Z = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MUL_RUN = 2'd1,
      ST_MUL_WB  = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  alu_mul_seq : shift-add multiplier, one multiplier bit per step, LSB first
//  Revision: 1.0
// ============================================================================
module alu_mul_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_i,
   input  logic                 step_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 last_o,
   output logic [2*WIDTH-1:0]   product_o
);

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CNT_W-1:0]   cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else if (start_i) begin
         mcand_q  <= {{WIDTH{1'b0}}, a_i};
         acc_q    <= '0;
         mplier_q <= b_i;
         cnt_q    <= CNT_W'(WIDTH - 1);
      end else if (step_i) begin
         if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
         mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   // The step taken while the counter reads zero consumes the final multiplier bit.
   assign last_o    = (cnt_q == '0);
   assign product_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  alu_seq : registered ALU with valid/ready on both sides and {C,N,V,Z} flags.
//  Define ALU_MUL_EN for the multi-cycle shift-add MUL.   Revision: 1.0
// ============================================================================
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_in_one,
   input  logic [WIDTH-1:0] alu_in_two,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_result,
   output logic [3:0]       alu_flags,
   output logic             busy
);

   if (WIDTH < 4 || WIDTH > 32 || CNT_W != $clog2(WIDTH)) begin : g_param_check
      $error("alu_seq: WIDTH must be 4..32 and CNT_W left at its default");
   end

   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;
   logic             out_free;
   logic             in_fire;
   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic [WIDTH-1:0] res_d;
   logic [3:0]       flg_d;

   assign out_free = !out_valid_q || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign add_w    = {1'b0, alu_in_one} + {1'b0, alu_in_two};
   assign sub_w    = {1'b0, alu_in_one} + {1'b0, ~alu_in_two} + (WIDTH+1)'(1);

   always_comb begin
      res_d = '0;
      flg_d = '0;
      case (alu_op)
         OP_SHL: begin
            res_d        = {alu_in_one[WIDTH-2:0], 1'b0};
            flg_d[FLG_C] = alu_in_one[WIDTH-1];
         end
         OP_ADD: begin
            res_d        = add_w[WIDTH-1:0];
            flg_d[FLG_C] = add_w[WIDTH];
            flg_d[FLG_V] = (alu_in_one[WIDTH-1] == alu_in_two[WIDTH-1]) &&
                           (add_w[WIDTH-1] != alu_in_one[WIDTH-1]);
         end
         OP_SHR: begin
            res_d        = {1'b0, alu_in_one[WIDTH-1:1]};
            flg_d[FLG_C] = alu_in_one[0];
         end
         OP_SUB: begin
            res_d        = sub_w[WIDTH-1:0];
            flg_d[FLG_C] = sub_w[WIDTH];
            flg_d[FLG_V] = (alu_in_one[WIDTH-1] != alu_in_two[WIDTH-1]) &&
                           (sub_w[WIDTH-1] != alu_in_one[WIDTH-1]);
         end
         OP_MUL: res_d = '0;
         OP_AND: res_d = alu_in_one & alu_in_two;
         OP_OR:  res_d = alu_in_one | alu_in_two;
         OP_XOR: res_d = alu_in_one ^ alu_in_two;
         default: res_d = '0;
      endcase
      flg_d[FLG_N] = res_d[WIDTH-1];
      flg_d[FLG_Z] = (res_d == '0);
   end

`ifdef ALU_MUL_EN
   state_e             state_q;
   logic               busy_q;
   logic               is_mul;
   logic               mul_last;
   logic [2*WIDTH-1:0] mul_prod;
   logic [3:0]         mul_flg;

   assign is_mul   = (alu_op == OP_MUL);
   assign in_ready = !reset && (state_q == ST_IDLE) && out_free;
   assign busy     = busy_q;

   alu_mul_seq #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start_i   (in_fire && is_mul),
      .step_i    (state_q == ST_MUL_RUN),
      .a_i       (alu_in_one),
      .b_i       (alu_in_two),
      .last_o    (mul_last),
      .product_o (mul_prod)
   );

   always_comb begin
      mul_flg        = '0;
      mul_flg[FLG_C] = |mul_prod[2*WIDTH-1:WIDTH];
      mul_flg[FLG_N] = mul_prod[WIDTH-1];
      mul_flg[FLG_Z] = (mul_prod[WIDTH-1:0] == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_fire && is_mul) begin
                  state_q <= ST_MUL_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_MUL_RUN: begin
               if (mul_last) begin
                  state_q <= ST_MUL_WB;
               end
            end
            ST_MUL_WB: begin
               if (out_free) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
         // Accepts only happen in IDLE, so these loads never collide.
         if (in_fire && !is_mul) begin
            out_valid_q <= 1'b1;
            result_q    <= res_d;
            flags_q     <= flg_d;
         end else if (state_q == ST_MUL_WB && out_free) begin
            out_valid_q <= 1'b1;
            result_q    <= mul_prod[WIDTH-1:0];
            flags_q     <= mul_flg;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end
`else
   assign in_ready = !reset && out_free;
   assign busy     = 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else if (in_fire) begin
         out_valid_q <= 1'b1;
         result_q    <= res_d;
         flags_q     <= flg_d;
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
`endif

   assign out_valid  = out_valid_q;
   assign alu_result = result_q;
   assign alu_flags  = flags_q;

endmodule
`default_nettype wire
